// File: rtl/tt_div_pkg.sv
// -----------------------------------------------------------------------------
// tt_div_pkg
// Shared constants and types for the sequential divider tile.
//
// Contents:
//   WIDTH / CNT_W   operand width and step-counter width
//   state_e         controller states {IDLE, RUN, DZ, FIX, DONE}
//   UIO_*           bit positions of the control/status bits on the uio bus
//   UIO_OE_MASK     output-enable pattern for the uio bus (status bits only)
//   magnitude()     two's-complement absolute value (signed build only)
//
// Build option: TT_DIV_SIGNED_EN (see tt_um_seq_divider) uses magnitude().
// -----------------------------------------------------------------------------
package tt_div_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  // FIX is reached only when TT_DIV_SIGNED_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DZ,
    FIX,
    DONE
  } state_e;

  // Control bits on uio_in.
  localparam int UIO_LD_A   = 0;
  localparam int UIO_LD_B   = 1;
  localparam int UIO_START  = 2;
  localparam int UIO_RD_SEL = 3;

  // Status bits on uio_out.
  localparam int UIO_BUSY = 4;
  localparam int UIO_DONE = 5;
  localparam int UIO_DBZ  = 6;

  localparam logic [7:0] UIO_OE_MASK = 8'b0111_0000;

  // |v| for a two's-complement value. -128 maps to 0x80, which read as an
  // unsigned magnitude is exactly 128, so the unsigned core handles it.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/tt_um_seq_divider_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//
// Ports:
//   rem       in   WIDTH  partial remainder before this step
//   work_msb  in   1      next dividend bit shifted into the remainder
//   divisor   in   WIDTH  divisor (unsigned)
//   rem_next  out  WIDTH  partial remainder after this step
//   q_bit     out  1      quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
  import tt_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             work_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  // After k steps the remainder is below 2^k, so before the final shift its
  // MSB is always 0 and dropping it loses nothing.
  assign shifted = {rem[WIDTH-2:0], work_msb};

  // One extra bit holds the borrow: trial[WIDTH] set means the subtraction
  // went negative and the shifted value is restored instead.
  assign trial    = {1'b0, shifted} - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted;

  logic unused_rem_msb;
  assign unused_rem_msb = rem[WIDTH-1];

endmodule

// File: rtl/tt_um_seq_divider.sv
// -----------------------------------------------------------------------------
// tt_um_seq_divider
// Sequential restoring divider tile: one quotient bit per enabled clock.
//
// Ports:
//   clk      in   1  clock
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  tile enable; low freezes all state
//   ui_in    in   8  operand byte, captured by ld_a / ld_b
//   uio_in   in   8  [0] ld_a  [1] ld_b  [2] start  [3] rd_sel  [7:4] unused
//   uo_out   out  8  quotient (rd_sel=0) or remainder (rd_sel=1)
//   uio_out  out  8  [4] busy  [5] done  [6] dbz, other bits 0
//   uio_oe   out  8  constant 8'b0111_0000
//
// Build option TT_DIV_SIGNED_EN: operands are two's complement. Magnitudes go
// through the same unsigned core and signs are applied in one FIX cycle, so
// a normal divide takes 9 cycles instead of 8. Divide-by-zero is unchanged.
// -----------------------------------------------------------------------------
module tt_um_seq_divider
  import tt_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;   // host-loaded operand A
  logic [WIDTH-1:0]   divisor_q,  divisor_d;    // host-loaded operand B
  logic [WIDTH-1:0]   op_b_q,     op_b_d;       // divisor snapshot for this op
  logic [WIDTH-1:0]   work_q,     work_d;       // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   rem_q,      rem_d;        // partial remainder
  logic [CNT_W-1:0]   count_q,    count_d;      // steps left after the current one
  logic               dbz_q,      dbz_d;
`ifdef TT_DIV_SIGNED_EN
  logic               neg_q_q,    neg_q_d;      // quotient must be negated
  logic               neg_r_q,    neg_r_d;      // remainder must be negated
`endif

  logic             ld_a;
  logic             ld_b;
  logic             start;
  logic             rd_sel;
  logic             load_ok;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  assign ld_a   = uio_in[UIO_LD_A];
  assign ld_b   = uio_in[UIO_LD_B];
  assign start  = uio_in[UIO_START];
  assign rd_sel = uio_in[UIO_RD_SEL];

  logic unused_uio_in;
  assign unused_uio_in = &{1'b0, uio_in[7:4]};

  // Operands may only change while no operation is in flight.
  assign load_ok = (state_q == IDLE) || (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Restoring step datapath
  // ---------------------------------------------------------------------------
  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .work_msb (work_q[WIDTH-1]),
    .divisor  (op_b_q),
    .rem_next (step_rem),
    .q_bit    (step_q_bit)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    op_b_d     = op_b_q;
    work_d     = work_q;
    rem_d      = rem_q;
    count_d    = count_q;
    dbz_d      = dbz_q;
`ifdef TT_DIV_SIGNED_EN
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
`endif

    // Loads land in the operand registers; an op starting on the same edge
    // reads the old values below, so the new byte is for the next op.
    if (load_ok) begin
      if (ld_a) dividend_d = ui_in;
      if (ld_b) divisor_d  = ui_in;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rem_d   = '0;
          count_d = CNT_W'(WIDTH - 1);
          dbz_d   = 1'b0;
`ifdef TT_DIV_SIGNED_EN
          op_b_d  = magnitude(divisor_q);
          neg_q_d = dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
          neg_r_d = dividend_q[WIDTH-1];
          // The DZ path returns the raw dividend, so keep it unconverted.
          work_d  = (divisor_q == '0) ? dividend_q : magnitude(dividend_q);
`else
          op_b_d  = divisor_q;
          work_d  = dividend_q;
`endif
          state_d = (divisor_q == '0) ? DZ : RUN;
        end
      end

      RUN: begin
        rem_d   = step_rem;
        work_d  = {work_q[WIDTH-2:0], step_q_bit};
        count_d = count_q - 1'b1;
        if (count_q == '0) begin
`ifdef TT_DIV_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end

      DZ: begin
        rem_d   = work_q;          // dividend captured at start
        work_d  = '1;
        dbz_d   = 1'b1;
        state_d = DONE;
      end

`ifdef TT_DIV_SIGNED_EN
      FIX: begin
        // Truncating division: quotient sign is the XOR of operand signs,
        // remainder follows the dividend. -128/-1 wraps to 0x80 naturally.
        if (neg_q_q) work_d = ~work_q + 1'b1;
        if (neg_r_q) rem_d  = ~rem_q + 1'b1;
        state_d = DONE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      op_b_q     <= '0;
      work_q     <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      dbz_q      <= 1'b0;
`ifdef TT_DIV_SIGNED_EN
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
`endif
    end else if (ena) begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      op_b_q     <= op_b_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      dbz_q      <= dbz_d;
`ifdef TT_DIV_SIGNED_EN
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic busy;
  logic done;

  assign busy = (state_q == RUN) || (state_q == DZ) || (state_q == FIX);
  assign done = (state_q == DONE);

  // Straight from registers; during RUN this shows partial values.
  assign uo_out = rd_sel ? rem_q : work_q;
  assign uio_oe = UIO_OE_MASK;

  always_comb begin
    uio_out           = '0;
    uio_out[UIO_BUSY] = busy;
    uio_out[UIO_DONE] = done;
    uio_out[UIO_DBZ]  = dbz_q;
  end

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_tt_um_seq_divider
// Directed bench for the sequential divider tile. A cycle-level model built
// from plain arithmetic (/ and %) plus a latency countdown tracks what the
// tile must show; a compare process checks status and results every cycle,
// and directed steps pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_tt_um_seq_divider;

`ifdef TT_DIV_SIGNED_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic ld_a, ld_b, start, rd_sel;
  assign uio_in = {4'b0000, rd_sel, start, ld_b, ld_a};

  always #5 clk = ~clk;

  tt_um_seq_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] m_a, m_b, m_q, m_r;
  bit         m_busy, m_done, m_dbz, m_dbz_pend;
  int         m_left;

  function automatic void model_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r);
    if (b == 8'h00) begin
      q = 8'hFF;
      r = a;
    end else begin
`ifdef TT_DIV_SIGNED_EN
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_q = 0; m_r = 0;
      m_busy = 0; m_done = 0; m_dbz = 0; m_dbz_pend = 0; m_left = 0;
    end else if (ena) begin
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          m_dbz  = m_dbz_pend;
        end
      end else begin
        if (start) begin
          model_div(m_a, m_b, m_q, m_r);
          m_dbz_pend = (m_b == 8'h00);
          m_dbz  = 0;
          m_done = 0;
          m_busy = 1;
          m_left = (m_b == 8'h00) ? 1 : LAT;
        end
        if (ld_a) m_a = ui_in;
        if (ld_b) m_b = ui_in;
      end
    end
  end

  // Compare process: status every cycle, results whenever not busy.
  always @(negedge clk) begin
    if (check_en) begin
      check("busy",  {7'b0, uio_out[4]}, {7'b0, m_busy});
      check("done",  {7'b0, uio_out[5]}, {7'b0, m_done});
      check("dbz",   {7'b0, uio_out[6]}, {7'b0, m_dbz});
      check("rsvd",  uio_out & 8'h8F, 8'h00);
      check("oe",    uio_oe, 8'h70);
      if (!m_busy) check("result", uo_out, rd_sel ? m_r : m_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (inputs change 1 ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    ui_in = a; ld_a = 1'b1;
    cyc();
    ui_in = b; ld_a = 1'b0; ld_b = 1'b1;
    cyc();
    ld_b = 1'b0;
  endtask

  // Counts edges after the start edge until done is visible.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!uio_out[5] && cycles < 40) begin
      cyc();
      cycles++;
    end
    if (!uio_out[5]) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, expected 1", uio_out[5], cycles);
    end
  endtask

  task automatic run(output int cycles);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(cycles);
  endtask

  task automatic expect_res(input string name, input logic [7:0] q,
                            input logic [7:0] r, input logic dbz);
    rd_sel = 1'b0; #1;
    check({name, "_q"}, uo_out, q);
    rd_sel = 1'b1; #1;
    check({name, "_r"}, uo_out, r);
    check({name, "_dbz"}, {7'b0, uio_out[6]}, {7'b0, dbz});
    rd_sel = 1'b0; #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int c;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b0; rd_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_en = 1'b1;

    // Reset state
    expect_res("reset", 8'h00, 8'h00, 1'b0);
    check("reset_status", uio_out, 8'h00);
    check("reset_oe", uio_oe, 8'h70);

`ifndef TT_DIV_SIGNED_EN
    load(8'd200, 8'd7);
    run(c);
    check("lat_200_7", 8'(c), 8'd8);
    expect_res("div_200_7", 8'h1C, 8'h04, 1'b0);

    load(8'd255, 8'd1);
    run(c);
    expect_res("div_255_1", 8'hFF, 8'h00, 1'b0);
`endif

    // Divide by zero
    load(8'h05, 8'h00);
    run(c);
    check("lat_dz", 8'(c), 8'd1);
    expect_res("div_5_0", 8'hFF, 8'h05, 1'b1);

    load(8'd3, 8'd10);
    run(c);
    expect_res("div_3_10", 8'h00, 8'h03, 1'b0);

    load(8'd0, 8'd9);
    run(c);
    expect_res("div_0_9", 8'h00, 8'h00, 1'b0);

    // Both loads in one cycle: a = b = 12
    ui_in = 8'd12; ld_a = 1'b1; ld_b = 1'b1;
    cyc();
    ld_a = 1'b0; ld_b = 1'b0;
    run(c);
    expect_res("div_12_12", 8'h01, 8'h00, 1'b0);

    // Back-to-back with start held, and ld_a during RUN ignored
    load(8'd50, 8'd5);
    start = 1'b1;
    cyc();
    wait_done(c);
    check("lat_b2b_first", 8'(c), 8'(LAT));
    expect_res("div_50_5", 8'd10, 8'h00, 1'b0);
    cyc();
    check("b2b_restart_busy", {7'b0, uio_out[4]}, 8'h01);
    start = 1'b0;
    ui_in = 8'h64; ld_a = 1'b1;
    cyc();
    ld_a = 1'b0;
    wait_done(c);
    check("lat_b2b_second", 8'(c), 8'(LAT - 1));
    expect_res("div_50_5_again", 8'd10, 8'h00, 1'b0);

    // ld_a together with start: this op uses 50, the next one 99
    ui_in = 8'd99; ld_a = 1'b1; start = 1'b1;
    cyc();
    ld_a = 1'b0; start = 1'b0;
    wait_done(c);
    expect_res("div_ldstart_old", 8'd10, 8'h00, 1'b0);
    run(c);
    expect_res("div_99_5", 8'd19, 8'd4, 1'b0);

    // Reset in the middle of RUN
    load(8'd200, 8'd7);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    expect_res("midrun_reset", 8'h00, 8'h00, 1'b0);
    check("midrun_reset_status", uio_out, 8'h00);
    cyc();
    rst_n = 1'b1;
    load(8'd100, 8'd9);
    run(c);
    check("lat_100_9", 8'(c), 8'(LAT));
    expect_res("div_100_9", 8'd11, 8'd1, 1'b0);

    // ena low for three edges mid-RUN stretches the latency by three
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    ena = 1'b0;
    repeat (3) cyc();
    ena = 1'b1;
    wait_done(c);
    check("lat_ena_stall", 8'(c), 8'(LAT - 2));
    expect_res("div_100_9_stall", 8'd11, 8'd1, 1'b0);

`ifdef TT_DIV_SIGNED_EN
    load(8'hF9, 8'h02);
    run(c);
    check("lat_signed", 8'(c), 8'd9);
    expect_res("sdiv_m7_2", 8'hFD, 8'hFF, 1'b0);

    load(8'h07, 8'hFE);
    run(c);
    expect_res("sdiv_7_m2", 8'hFD, 8'h01, 1'b0);

    load(8'h80, 8'hFF);
    run(c);
    expect_res("sdiv_m128_m1", 8'h80, 8'h00, 1'b0);
`endif

    cyc();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tt_um_seq_divider.md
Name: tt_um_seq_divider

Overview:
- Companion tile to the combinational adder tile. Runs the inverse operation: unsigned restoring division built from repeated subtract-and-shift.
- Produces one quotient bit per clock.
- Operands are loaded byte-wise through ui_in under strobes on uio_in. Results are read back on uo_out.
- A start/busy/done handshake on uio pins sequences the operation.

Parameters:
- WIDTH, 8, operand/result width; fixed at 8 by the tile pinout, exposed only for the step sub-module.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  tile enable; low freezes all state (acts as clock enable).
- ui_in  in  8  operand byte, captured by ld_a / ld_b.
- uio_in  in  8  control bits:
  - [0] ld_a: capture dividend.
  - [1] ld_b: capture divisor.
  - [2] start.
  - [3] rd_sel: 0 = quotient, 1 = remainder.
  - [7:4] unused.
- uo_out  out  8  quotient or remainder, per rd_sel.
- uio_out  out  8  status bits:
  - [4] busy.
  - [5] done.
  - [6] dbz (divide-by-zero).
  - all other bits 0.
- uio_oe  out  8  constant 8'b0111_0000.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; dividend, divisor, quotient, remainder and step counter = 0.
  - busy = done = dbz = 0; uo_out = 0.
- States and transitions:
  - IDLE: operands loadable. start → RUN, or DZ if divisor == 0.
  - RUN: one restoring step per edge. The last step (count == 0) → DONE.
  - DZ: one cycle → DONE with the error result.
  - DONE: results held. start → RUN/DZ again (restart without returning to IDLE). Operands remain loadable.
- ld_a / ld_b:
  - Sampled in IDLE and DONE only; ignored in RUN and DZ.
  - Both high in the same cycle loads ui_in into both registers.
  - A ld in the same cycle as start: start uses the previously held operand values; the new value lands for the next op.
- Start:
  - Level-sampled; start held high in DONE restarts every cycle.
  - On the start edge: remainder accumulator := 0, work register := dividend, counter := WIDTH-1, done/dbz clear, busy := 1.
- Step (each RUN edge):
  - trial = {rem[6:0], work[7]} − divisor, computed 9 bits wide.
  - trial non-negative: rem := trial[7:0] and shift in q-bit 1.
  - Otherwise: rem := shifted value and shift in 0.
  - work shifts left.
- Latency:
  - Start sampled at edge t → busy visible after t.
  - Done and final results visible after edge t+8; busy falls at the same edge.
  - DZ path: done after edge t+1.
- Divide by zero: quotient = 0xFF, remainder = dividend, dbz = 1 until the next start.
- Output mux:
  - uo_out = rd_sel ? remainder : quotient, registered results only (combinational mux).
  - During RUN, uo_out shows the partial registers; contents are undefined by contract.
- Other conditions:
  - start during RUN/DZ: ignored; no restart or abort.
  - rst_n asserted mid-RUN: immediate return to reset values; no partial result retained.
  - ena low mid-RUN: counter and registers frozen; resumes on ena high; latency extends accordingly.

Optional Feature:
- Macro: TT_DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are divided by the same unsigned core; signs are fixed up in one extra FIX cycle, so latency is 9 (DZ path unchanged).
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - −128 / −1 → quotient 0x80 (wraps), remainder 0x00.
  - Divide by zero → quotient 0xFF, remainder = dividend.
- Undefined: unsigned only, no FIX state, latency 8.

Decomposition:
- Package tt_div_pkg:
  - WIDTH localparam.
  - State enum {IDLE, RUN, DZ, FIX, DONE}.
  - uio bit-index localparams (LD_A, LD_B, START, RD_SEL, BUSY, DONE, DBZ).
  - UIO_OE_MASK constant.
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, work MSB, divisor.
  - Outputs: next rem, q bit.
  - Instantiated once inside the top FSM.

Test Plan:
- Load a=200, b=7, start → done after 8 cycles. Quotient 28 (0x1C), remainder 4; dbz=0.
- a=0x05, b=0x00, start → done after 1 cycle. Quotient 0xFF, remainder 0x05, dbz=1.
- a=255/b=1 → q 255, r 0. a=3/b=10 → q 0, r 3. a=0/b=9 → q 0, r 0.
- Back-to-back: start held high through DONE → second op begins the cycle after done. Pulse ld_a=0x64 during RUN → ignored; result uses the old a.
- Reset mid-RUN at step 4 → all outputs 0 and IDLE; next op 100/9 → q 11, r 1.
- Signed build: −7/2 → q 0xFD, r 0xFF. 7/−2 → q 0xFD, r 0x01. −128/−1 → q 0x80, r 0x00. Latency 9.
